icache_refill_engine: RTL and testbench
=======================================

// Module: icache_refill_engine
// PURPOSE
//  Miss-side refill stage. Sits downstream of the icache tag lookup and upstream of the data/tag RAMs.
//  - Accepts one miss at a time and issues a critical-beat-first line read on the L2 bus.
//  - Writes each returned beat into its 128-bit data-RAM bank and forwards the critical beat to the CPU.
//  - Finishes by writing {valid,tag} into the victim way.
// PARAMETERS
//  ADDR_W      32   request/bus address width
//  LINE_BYTES  64   cache line size (B)
//  BUS_W       128  L2 data beat width = one data-RAM bank width
//  INDEX_W     8    set index width
//  TAG_W       18   tag width; ADDR_W = TAG_W+INDEX_W+log2(LINE_BYTES)
//  WAYS        2    associativity; WAY_W = log2(WAYS)
//  Derived: BEATS = LINE_BYTES*8/BUS_W (4); BANK_W = log2(BEATS) (2)
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        reset, synchronous, active-high (port keeps codebase name)
//  miss_valid     in   1        miss request valid
//  miss_ready     out  1        refill engine can accept a miss
//  miss_addr      in   ADDR_W   missing fetch address
//  victim_way     in   WAY_W    way to fill (LRU); sampled with the miss
//  invalidate     in   1        icache invalidate; poisons any in-flight fill
//  bus_req        out  1        L2 read request
//  bus_addr       out  ADDR_W   {tag,index,crit_bank,4'b0}
//  bus_ack        in   1        L2 accepted the request
//  bus_data_valid in   1        beat valid
//  bus_data       in   BUS_W    beat data
//  dram_wr_en     out  1        data-RAM write strobe
//  dram_wr_way    out  WAY_W    target way
//  dram_wr_bank   out  BANK_W   target bank
//  dram_wr_index  out  INDEX_W  target set
//  dram_wr_data   out  BUS_W    write data
//  tag_wr_en      out  1        tag-RAM write strobe
//  tag_wr_way     out  WAY_W    target way
//  tag_wr_index   out  INDEX_W  target set
//  tag_wr_data    out  TAG_W+1  {valid,tag}
//  crit_valid     out  1        critical beat forwarded to CPU (1-cycle pulse)
//  crit_data      out  BUS_W    critical beat
//  refill_done    out  1        1-cycle pulse: line complete
//  busy           out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0, except miss_ready=1; poison flag cleared.
//    A reset mid-refill abandons the fill with no tag write; the L2 bus shares this reset.
//  - FSM: IDLE -> REQ -> DATA -> TAGWR -> IDLE.
//  - IDLE: miss_ready=1. On miss_valid, capture the address fields and victim_way.
//    crit_bank = miss_addr[5:4]; go to REQ.
//  - REQ: bus_req=1 and bus_addr stable, both registered.
//    bus_req is held until the bus_ack cycle and drops the following cycle; then go to DATA.
//  - DATA: beat counter k runs 0..BEATS-1 and advances only on bus_data_valid.
//    Beat k at cycle T -> dram_wr_en=1 at T+1, with bank = (crit_bank+k) mod BEATS (2-bit wrap).
//    Index and way come from the captured miss. dram_wr_data = beat.
//  - Critical beat: beat 0 also drives crit_valid=1 / crit_data at T+1.
//    crit_valid is suppressed if poisoned.
//  - Last beat (k=BEATS-1) -> TAGWR. The final dram write and the tag write share the TAGWR cycle.
//  - TAGWR: tag_wr_en=1, tag_wr_data={~poison,tag}, refill_done=1 for one cycle; then IDLE.
//    miss_ready returns to 1 the next cycle.
//  - Gaps between beats are allowed; beats may not arrive before the cycle after bus_ack.
//    bus_data_valid outside DATA is ignored.
//  - invalidate: in IDLE, no effect. In any other state, set poison.
//    The fill still completes (the bus cannot be cancelled), but the valid bit is written 0.
//    invalidate in the TAGWR cycle itself also poisons. Poison clears on entering IDLE.
//  - miss_valid while busy: not accepted (miss_ready=0); no queueing.
//  - Minimum miss-to-done: accept N; bus_req N+1; ack N+1; beats N+2..N+5; tag write N+6.
// STRUCTURE
//  - icache_pkg holds:
//    - width localparams (TAG_W, INDEX_W, BANK_W, BEATS)
//    - typedef enum logic [1:0] refill_state_e {IDLE,REQ,DATA,TAGWR}
//    - typedef struct refill_req_t {tag,index,crit_bank,way}
//  - Single module, no sub-module: counter, bank rotate and FSM are small and tightly coupled.
// TESTING
//  - Basic: miss 0x0001_2340 (crit_bank 0), way 1, bus_ack 1 cycle later, 4 back-to-back beats.
//    -> bus_addr 0x0001_2340; banks 0,1,2,3 on index 0x8D.
//    -> tag_wr_data {1,18'h00004} on way 1; refill_done at N+6.
//  - Critical wrap: miss 0x0001_2370 (crit_bank 3).
//    -> bus_addr 0x0001_2370; bank order 3,0,1,2; crit_valid with beat 0 data at first-beat+1.
//  - Backpressure: bus_ack delayed 5 cycles, then 2 idle cycles between each beat.
//    -> bus_req held 6 cycles; exactly 4 dram writes; no spurious writes in gaps.
//  - Invalidate mid-fill: invalidate asserted after beat 1.
//    -> all 4 dram writes occur; tag_wr_data valid bit=0; crit_valid still seen (pre-invalidate).
//    -> next miss fills with valid=1.
//  - Busy reject and stray beat: miss_valid held during DATA and bus_data_valid pulsed in IDLE.
//    -> miss_ready=0 until TAGWR+1, then the held miss is accepted; the stray beat causes no write.
//  - Reset mid-DATA after 2 beats.
//    -> next cycle all outputs 0, miss_ready=1, no tag write; a fresh miss completes normally.

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared widths, FSM state type and the captured-miss record for the icache
// refill engine.
//   ADDR_W / TAG_W / INDEX_W : address split {tag, index, line offset}
//   BUS_W                    : L2 beat width, equal to one data-RAM bank
//   BEATS / BANK_W           : beats per line and bank-select width
// -----------------------------------------------------------------------------
package icache_pkg;

   localparam int ADDR_W     = 32;
   localparam int LINE_BYTES = 64;
   localparam int BUS_W      = 128;
   localparam int INDEX_W    = 8;
   localparam int TAG_W      = 18;
   localparam int WAYS       = 2;

   localparam int WAY_W      = $clog2(WAYS);
   localparam int OFFSET_W   = $clog2(LINE_BYTES);
   localparam int BEATS      = LINE_BYTES * 8 / BUS_W;
   localparam int BANK_W     = $clog2(BEATS);
   // byte offset within one beat; always zero on the bus address
   localparam int BEAT_OFS_W = $clog2(BUS_W / 8);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DATA  = 2'd2,
      TAGWR = 2'd3
   } refill_state_e;

   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [INDEX_W-1:0] index;
      logic [BANK_W-1:0]  crit_bank;
      logic [WAY_W-1:0]   way;
   } refill_req_t;

   // Split a miss address (beat byte offset already dropped) into the fields
   // the refill needs. The bank bits pick which beat the CPU is waiting for.
   function automatic refill_req_t decode_miss(
      input logic [ADDR_W-BEAT_OFS_W-1:0] addr_hi,
      input logic [WAY_W-1:0]             way
   );
      refill_req_t req;
      req.tag       = addr_hi[ADDR_W-BEAT_OFS_W-1 -: TAG_W];
      req.index     = addr_hi[BANK_W +: INDEX_W];
      req.crit_bank = addr_hi[BANK_W-1:0];
      req.way       = way;
      return req;
   endfunction

endpackage

// File: rtl/icache_refill_engine_if.sv
// -----------------------------------------------------------------------------
// icache_refill_engine_if
// Groups the miss request, L2 read bus, data/tag RAM write ports and CPU
// forwarding signals of the refill engine.
//   slave  : the refill engine itself
//   master : the surrounding icache / L2 / RAM environment
// -----------------------------------------------------------------------------
interface icache_refill_engine_if;
   import icache_pkg::*;

   // miss request from tag lookup
   logic                 miss_valid;
   logic                 miss_ready;
   logic [ADDR_W-1:0]    miss_addr;
   logic [WAY_W-1:0]     victim_way;
   logic                 invalidate;
   // L2 read bus
   logic                 bus_req;
   logic [ADDR_W-1:0]    bus_addr;
   logic                 bus_ack;
   logic                 bus_data_valid;
   logic [BUS_W-1:0]     bus_data;
   // data-RAM write port
   logic                 dram_wr_en;
   logic [WAY_W-1:0]     dram_wr_way;
   logic [BANK_W-1:0]    dram_wr_bank;
   logic [INDEX_W-1:0]   dram_wr_index;
   logic [BUS_W-1:0]     dram_wr_data;
   // tag-RAM write port
   logic                 tag_wr_en;
   logic [WAY_W-1:0]     tag_wr_way;
   logic [INDEX_W-1:0]   tag_wr_index;
   logic [TAG_W:0]       tag_wr_data;
   // CPU forwarding and status
   logic                 crit_valid;
   logic [BUS_W-1:0]     crit_data;
   logic                 refill_done;
   logic                 busy;

   modport slave (
      input  miss_valid, miss_addr, victim_way, invalidate,
             bus_ack, bus_data_valid, bus_data,
      output miss_ready, bus_req, bus_addr,
             dram_wr_en, dram_wr_way, dram_wr_bank, dram_wr_index, dram_wr_data,
             tag_wr_en, tag_wr_way, tag_wr_index, tag_wr_data,
             crit_valid, crit_data, refill_done, busy
   );

   modport master (
      output miss_valid, miss_addr, victim_way, invalidate,
             bus_ack, bus_data_valid, bus_data,
      input  miss_ready, bus_req, bus_addr,
             dram_wr_en, dram_wr_way, dram_wr_bank, dram_wr_index, dram_wr_data,
             tag_wr_en, tag_wr_way, tag_wr_index, tag_wr_data,
             crit_valid, crit_data, refill_done, busy
   );

endinterface

// File: rtl/icache_refill_engine.sv
// -----------------------------------------------------------------------------
// icache_refill_engine
// Miss-side refill stage: accepts one miss at a time, issues a critical-beat-
// first line read on L2, writes each returned beat into its data-RAM bank,
// forwards the critical beat to the CPU and finally writes {valid,tag} into
// the victim way. An invalidate during a fill lets the fill finish but writes
// the line back as invalid.
// Ports:
//   clk    : clock
//   rst_n  : synchronous reset, active HIGH (name kept from the codebase)
//   io_bus : icache_refill_engine_if.slave (miss, L2 bus, RAM writes, CPU fwd)
// -----------------------------------------------------------------------------
module icache_refill_engine
   import icache_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   icache_refill_engine_if.slave   io_bus
);

   refill_state_e       r_state;
   refill_state_e       w_state_nxt;
   refill_req_t         r_req;
   logic [BANK_W-1:0]   r_beat_cnt;
   logic                r_poison;

   logic                r_bus_req;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic                r_dram_wr_en;
   logic [WAY_W-1:0]    r_dram_wr_way;
   logic [BANK_W-1:0]   r_dram_wr_bank;
   logic [INDEX_W-1:0]  r_dram_wr_index;
   logic [BUS_W-1:0]    r_dram_wr_data;
   logic                r_crit_valid;
   logic [BUS_W-1:0]    r_crit_data;

   logic                w_accept;
   logic                w_beat;
   logic                w_last_beat;
   logic                w_poison;
   logic                w_tag_wr;

   assign w_accept    = (r_state == IDLE) && io_bus.miss_valid;
   // beats are only meaningful while collecting the line
   assign w_beat      = (r_state == DATA) && io_bus.bus_data_valid;
   assign w_last_beat = w_beat && (r_beat_cnt == BANK_W'(BEATS - 1));
   // an invalidate in the current cycle counts as poison immediately, so one
   // landing in the tag-write cycle still clears the valid bit
   assign w_poison    = r_poison | io_bus.invalidate;
   assign w_tag_wr    = (r_state == TAGWR);

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // sequential block sees the pre-edge value regardless of block order.
      if (rst_n) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: default assigned first so no path leaves the signal unassigned,
      // which would otherwise infer a latch.
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (io_bus.miss_valid) w_state_nxt = REQ;
         REQ:     if (io_bus.bus_ack)    w_state_nxt = DATA;
         DATA:    if (w_last_beat)       w_state_nxt = TAGWR;
         TAGWR:                          w_state_nxt = IDLE;
         default:                        w_state_nxt = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath ---
   always_ff @(posedge clk) begin
      // NOTE: wide data registers are reset too, because every output must
      // read 0 after reset; they are plain flops, not RAM, so this is cheap.
      if (rst_n) begin
         r_req           <= '0;
         r_beat_cnt      <= '0;
         r_poison        <= 1'b0;
         r_bus_req       <= 1'b0;
         r_bus_addr      <= '0;
         r_dram_wr_en    <= 1'b0;
         r_dram_wr_way   <= '0;
         r_dram_wr_bank  <= '0;
         r_dram_wr_index <= '0;
         r_dram_wr_data  <= '0;
         r_crit_valid    <= 1'b0;
         r_crit_data     <= '0;
      end else begin
         r_dram_wr_en <= w_beat;
         r_crit_valid <= 1'b0;

         if (w_accept) begin
            r_req      <= decode_miss(io_bus.miss_addr[ADDR_W-1:BEAT_OFS_W],
                                      io_bus.victim_way);
            r_bus_req  <= 1'b1;
            // critical-beat-first: the bus address carries the missing bank
            r_bus_addr <= {io_bus.miss_addr[ADDR_W-1:BEAT_OFS_W],
                           {BEAT_OFS_W{1'b0}}};
            r_beat_cnt <= '0;
         end

         if ((r_state == REQ) && io_bus.bus_ack) r_bus_req <= 1'b0;

         if (w_beat) begin
            // 2-bit add wraps naturally, giving the rotated bank order
            r_dram_wr_bank  <= r_req.crit_bank + r_beat_cnt;
            r_dram_wr_way   <= r_req.way;
            r_dram_wr_index <= r_req.index;
            r_dram_wr_data  <= io_bus.bus_data;
            r_beat_cnt      <= r_beat_cnt + BANK_W'(1);
            if (r_beat_cnt == '0) begin
               r_crit_valid <= ~w_poison;
               r_crit_data  <= io_bus.bus_data;
            end
         end

         if (w_state_nxt == IDLE)                           r_poison <= 1'b0;
         else if ((r_state != IDLE) && io_bus.invalidate)   r_poison <= 1'b1;
      end
   end

   // ------------------------------------------------------------ outputs ---
   assign io_bus.miss_ready    = (r_state == IDLE);
   assign io_bus.busy          = (r_state != IDLE);
   assign io_bus.bus_req       = r_bus_req;
   assign io_bus.bus_addr      = r_bus_addr;

   assign io_bus.dram_wr_en    = r_dram_wr_en;
   assign io_bus.dram_wr_way   = r_dram_wr_way;
   assign io_bus.dram_wr_bank  = r_dram_wr_bank;
   assign io_bus.dram_wr_index = r_dram_wr_index;
   assign io_bus.dram_wr_data  = r_dram_wr_data;

   // tag write fields are forced to 0 outside the tag-write cycle
   assign io_bus.tag_wr_en     = w_tag_wr;
   assign io_bus.tag_wr_way    = w_tag_wr ? r_req.way   : '0;
   assign io_bus.tag_wr_index  = w_tag_wr ? r_req.index : '0;
   assign io_bus.tag_wr_data   = w_tag_wr ? {~w_poison, r_req.tag} : '0;
   assign io_bus.refill_done   = w_tag_wr;

   assign io_bus.crit_valid    = r_crit_valid;
   assign io_bus.crit_data     = r_crit_data;

endmodule

// File: tb/tb_icache_refill_engine.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_engine
// Directed self-checking bench for icache_refill_engine. Each refill is driven
// cycle by cycle with hand-computed tag/index/bank expectations; outputs are
// sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_icache_refill_engine;
   import icache_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   icache_refill_engine_if u_if();

   icache_refill_engine u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (u_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BUS_W-1:0] beat_pat(input int k, input logic [15:0] seed);
      logic [7:0] kb;
      kb = 8'(k);
      return {4{seed, 8'hA5, kb}};
   endfunction

   // One complete refill. Cycle 0 is the accept cycle; returns the number of
   // cycles bus_req was seen high and the cycle index of the tag write.
   task automatic run_refill(
      input  logic [ADDR_W-1:0]  addr,
      input  logic [WAY_W-1:0]   way,
      input  logic [TAG_W-1:0]   exp_tag,
      input  logic [INDEX_W-1:0] exp_index,
      input  logic [BANK_W-1:0]  exp_bank,
      input  int                 ack_dly,
      input  int                 gap,
      input  int                 inval_beat,
      input  bit                 keep_miss,
      input  bit                 exp_valid,
      input  bit                 exp_crit,
      output int                 req_cycles,
      output int                 done_cycle
   );
      int cyc;
      logic [BANK_W-1:0] eb;
      cyc        = 0;
      req_cycles = 0;
      check("miss_ready_idle", u_if.miss_ready, 1);
      u_if.miss_valid = 1'b1;
      u_if.miss_addr  = addr;
      u_if.victim_way = way;
      tick; cyc++;
      if (!keep_miss) u_if.miss_valid = 1'b0;
      check("bus_addr", u_if.bus_addr, {exp_tag, exp_index, exp_bank, 4'h0});
      check("miss_ready_busy_req", u_if.miss_ready, 0);
      for (int i = 0; i <= ack_dly; i++) begin
         if (u_if.bus_req) req_cycles++;
         if (i == ack_dly) u_if.bus_ack = 1'b1;
         tick; cyc++;
         u_if.bus_ack = 1'b0;
      end
      check("bus_req_drop", u_if.bus_req, 0);
      for (int k = 0; k < BEATS; k++) begin
         if (k > 0) begin
            repeat (gap) begin
               tick; cyc++;
               check("gap_no_write", u_if.dram_wr_en, 0);
            end
         end
         u_if.bus_data_valid = 1'b1;
         u_if.bus_data       = beat_pat(k, addr[15:0]);
         u_if.invalidate     = (inval_beat >= 0) && (k == inval_beat + 1);
         tick; cyc++;
         u_if.bus_data_valid = 1'b0;
         u_if.invalidate     = 1'b0;
         eb = exp_bank + BANK_W'(k);
         check("dram_wr_en",    u_if.dram_wr_en, 1);
         check("dram_wr_bank",  u_if.dram_wr_bank, eb);
         check("dram_wr_index", u_if.dram_wr_index, exp_index);
         check("dram_wr_way",   u_if.dram_wr_way, way);
         check("dram_wr_data",  u_if.dram_wr_data, beat_pat(k, addr[15:0]));
         check("miss_ready_busy_data", u_if.miss_ready, 0);
         if (k == 0) begin
            check("crit_valid", u_if.crit_valid, exp_crit);
            check("crit_data",  u_if.crit_data, beat_pat(0, addr[15:0]));
         end else begin
            check("crit_valid_once", u_if.crit_valid, 0);
         end
      end
      check("tag_wr_en",    u_if.tag_wr_en, 1);
      check("tag_wr_way",   u_if.tag_wr_way, way);
      check("tag_wr_index", u_if.tag_wr_index, exp_index);
      check("tag_wr_data",  u_if.tag_wr_data, {exp_valid, exp_tag});
      check("refill_done",  u_if.refill_done, 1);
      check("miss_ready_tagwr", u_if.miss_ready, 0);
      done_cycle = cyc;
      tick;
      check("miss_ready_after", u_if.miss_ready, 1);
      check("done_pulse_end",   u_if.refill_done, 0);
      check("tag_wr_en_end",    u_if.tag_wr_en, 0);
      check("dram_wr_en_end",   u_if.dram_wr_en, 0);
      check("busy_end",         u_if.busy, 0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_miss_ready"},  u_if.miss_ready, 1);
      check({pfx, "_busy"},        u_if.busy, 0);
      check({pfx, "_bus_req"},     u_if.bus_req, 0);
      check({pfx, "_bus_addr"},    u_if.bus_addr, 0);
      check({pfx, "_dram_wr_en"},  u_if.dram_wr_en, 0);
      check({pfx, "_dram_bank"},   u_if.dram_wr_bank, 0);
      check({pfx, "_dram_data"},   u_if.dram_wr_data, 0);
      check({pfx, "_tag_wr_en"},   u_if.tag_wr_en, 0);
      check({pfx, "_tag_wr_data"}, u_if.tag_wr_data, 0);
      check({pfx, "_crit_valid"},  u_if.crit_valid, 0);
      check({pfx, "_crit_data"},   u_if.crit_data, 0);
      check({pfx, "_refill_done"}, u_if.refill_done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int rq, dn;
      rst_n               = 1'b1;
      u_if.miss_valid     = 1'b0;
      u_if.miss_addr      = '0;
      u_if.victim_way     = '0;
      u_if.invalidate     = 1'b0;
      u_if.bus_ack        = 1'b0;
      u_if.bus_data_valid = 1'b0;
      u_if.bus_data       = '0;
      repeat (3) tick;
      rst_n = 1'b0;
      check_reset_outputs("reset");

      // basic: crit bank 0, way 1, tag 4, index 8D, minimum latency
      run_refill(32'h0001_2340, 1'b1, 18'h00004, 8'h8D, 2'd0,
                 0, 0, -1, 1'b0, 1'b1, 1'b1, rq, dn);
      check("basic_req_cycles", rq, 1);
      check("basic_done_cycle", dn, 6);

      // critical wrap: bank order 3,0,1,2
      run_refill(32'h0001_2370, 1'b0, 18'h00004, 8'h8D, 2'd3,
                 0, 0, -1, 1'b0, 1'b1, 1'b1, rq, dn);
      check("wrap_done_cycle", dn, 6);

      // backpressure: ack 5 cycles late, 2 idle cycles between beats
      run_refill(32'h0ABC_D5A0, 1'b1, 18'h02AF3, 8'h56, 2'd2,
                 5, 2, -1, 1'b0, 1'b1, 1'b1, rq, dn);
      check("bp_req_cycles", rq, 6);
      check("bp_done_cycle", dn, 17);

      // invalidate after beat 1: fill completes, line written invalid
      run_refill(32'h0001_2340, 1'b0, 18'h00004, 8'h8D, 2'd0,
                 0, 0, 1, 1'b0, 1'b0, 1'b1, rq, dn);
      // next miss fills valid again
      run_refill(32'h0001_2380, 1'b1, 18'h00004, 8'h8E, 2'd0,
                 0, 0, -1, 1'b0, 1'b1, 1'b1, rq, dn);

      // stray beat in IDLE
      u_if.bus_data_valid = 1'b1;
      u_if.bus_data       = beat_pat(7, 16'hDEAD);
      tick;
      u_if.bus_data_valid = 1'b0;
      check("stray_no_write", u_if.dram_wr_en, 0);
      check("stray_no_crit",  u_if.crit_valid, 0);
      check("stray_idle",     u_if.busy, 0);

      // busy reject: miss held through the fill, accepted at TAGWR+1
      run_refill(32'h0001_2370, 1'b1, 18'h00004, 8'h8D, 2'd3,
                 0, 0, -1, 1'b1, 1'b1, 1'b1, rq, dn);
      run_refill(32'h0001_2370, 1'b1, 18'h00004, 8'h8D, 2'd3,
                 0, 0, -1, 1'b0, 1'b1, 1'b1, rq, dn);

      // reset mid-DATA after two beats
      u_if.miss_valid = 1'b1;
      u_if.miss_addr  = 32'h0001_2340;
      u_if.victim_way = 1'b1;
      tick;
      u_if.miss_valid = 1'b0;
      u_if.bus_ack    = 1'b1;
      tick;
      u_if.bus_ack    = 1'b0;
      for (int k = 0; k < 2; k++) begin
         u_if.bus_data_valid = 1'b1;
         u_if.bus_data       = beat_pat(k, 16'h5555);
         tick;
      end
      u_if.bus_data_valid = 1'b0;
      check("pre_reset_busy", u_if.busy, 1);
      rst_n = 1'b1;
      tick;
      rst_n = 1'b0;
      check_reset_outputs("midrst");
      tick;
      check("midrst_no_tag_wr", u_if.tag_wr_en, 0);
      run_refill(32'h0ABC_D5A0, 1'b0, 18'h02AF3, 8'h56, 2'd2,
                 0, 0, -1, 1'b0, 1'b1, 1'b1, rq, dn);
      check("post_rst_done_cycle", dn, 6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
